// File: rtl/sprite_cmd_pkg.sv
// rtl/sprite_cmd_pkg.sv - sprite command word fields, codes and encoder state enum
package sprite_cmd_pkg;

    localparam int COMP_W  = 6;
    localparam int CHILD_W = 5;
    localparam int ACT_W   = 4;
    localparam int TYPE_W  = 3;
    localparam int DATA_W  = 13;

    localparam int COMP_LSB   = 26;
    localparam int CHILD_LSB  = 21;
    localparam int ACT_LSB    = 17;
    localparam int TYPE_LSB   = 14;
    localparam int TOGGLE_BIT = 13;

    localparam logic [ACT_W-1:0] ACT_UPDATE = 4'b0001;
    localparam logic [ACT_W-1:0] ACT_COMMIT = 4'b1111;

    localparam logic [TYPE_W-1:0] TYPE_NONE    = 3'b000;
    localparam logic [TYPE_W-1:0] TYPE_VISFLIP = 3'b001;
    localparam logic [TYPE_W-1:0] TYPE_X       = 3'b010;
    localparam logic [TYPE_W-1:0] TYPE_Y       = 3'b011;
    localparam logic [TYPE_W-1:0] TYPE_ATTR    = 3'b100;

    localparam logic [COMP_W-1:0] NOP_COMPONENT = 6'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPD    = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    typedef struct packed {
        logic [COMP_W-1:0]  component;
        logic [CHILD_W-1:0] child;
        logic               visible;
        logic               flip;
        logic [9:0]         x;
        logic [9:0]         y;
        logic [9:0]         attr;
    } upd_req_t;

    // Update words go out in a fixed order: vis/flip, x, y, attr.
    function automatic logic [TYPE_W-1:0] upd_type(input logic [1:0] idx);
        case (idx)
            2'd0:    return TYPE_VISFLIP;
            2'd1:    return TYPE_X;
            2'd2:    return TYPE_Y;
            default: return TYPE_ATTR;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] upd_data(input upd_req_t r, input logic [1:0] idx);
        case (idx)
            2'd0:    return {r.visible, r.flip, 11'd0};
            2'd1:    return {3'd0, r.x};
            2'd2:    return {3'd0, r.y};
            default: return {3'd0, r.attr};
        endcase
    endfunction

endpackage

// File: rtl/sprite_cmd_encoder_if.sv
// rtl/sprite_cmd_encoder_if.sv - request, commit and command-word bus of the sprite encoder
interface sprite_cmd_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_component;
    logic [4:0]  req_child;
    logic        req_visible;
    logic        req_flip;
    logic [9:0]  req_x;
    logic [9:0]  req_y;
    logic [9:0]  req_attr;
    logic        commit_req;
    logic [31:0] writedata;
    logic        wr_valid;
    logic        wr_ready;
    logic        back_buf;
    logic        busy;
    logic        commit_done;

    modport master (
        output req_valid, req_component, req_child, req_visible, req_flip,
               req_x, req_y, req_attr, commit_req, wr_ready,
        input  req_ready, writedata, wr_valid, back_buf, busy, commit_done
    );

    modport slave (
        input  req_valid, req_component, req_child, req_visible, req_flip,
               req_x, req_y, req_attr, commit_req, wr_ready,
        output req_ready, writedata, wr_valid, back_buf, busy, commit_done
    );
endinterface

// File: rtl/sprite_cmd_pack.sv
// rtl/sprite_cmd_pack.sv - combinational packer for 32-bit sprite command words
module sprite_cmd_pack
    import sprite_cmd_pkg::*;
(
    input  logic [COMP_W-1:0]  component_i,
    input  logic [CHILD_W-1:0] child_i,
    input  logic [ACT_W-1:0]   action_i,
    input  logic [TYPE_W-1:0]  type_i,
    input  logic               toggle_i,
    input  logic [DATA_W-1:0]  data_i,
    output logic [31:0]        word_o
);
    assign word_o = {component_i, child_i, action_i, type_i, toggle_i, data_i};
endmodule

// File: rtl/sprite_cmd_encoder.sv
// rtl/sprite_cmd_encoder.sv - serialises sprite updates and frame commits into command words
module sprite_cmd_encoder
    import sprite_cmd_pkg::*;
#(
    parameter logic [63:0] COMP_MASK = 64'h0000_0000_0000_0400,
    parameter logic [31:0] IDLE_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    sprite_cmd_if.slave bus
);

    state_e             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [COMP_W-1:0]  scan_q, scan_d;
    logic               pending_q, pending_d;
    logic               back_buf_q, back_buf_d;
    logic               done_q, done_d;
    upd_req_t           req_q, req_d;

    logic               wr_valid_c;
    logic               wr_fire;
    logic [COMP_W-1:0]  f_comp;
    logic [CHILD_W-1:0] f_child;
    logic [ACT_W-1:0]   f_act;
    logic [TYPE_W-1:0]  f_type;
    logic [DATA_W-1:0]  f_data;
    logic [31:0]        packed_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            scan_q     <= '0;
            pending_q  <= 1'b0;
            back_buf_q <= 1'b1;
            done_q     <= 1'b0;
            req_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            scan_q     <= scan_d;
            pending_q  <= pending_d;
            back_buf_q <= back_buf_d;
            done_q     <= done_d;
            req_q      <= req_d;
        end
    end

    assign wr_fire = wr_valid_c && bus.wr_ready;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        scan_d     = scan_q;
        pending_d  = pending_q | bus.commit_req;
        back_buf_d = back_buf_q;
        done_d     = 1'b0;
        req_d      = req_q;
        wr_valid_c = 1'b0;
        f_comp     = NOP_COMPONENT;
        f_child    = '0;
        f_act      = '0;
        f_type     = TYPE_NONE;
        f_data     = '0;

        case (state_q)
            ST_IDLE: begin
                // Pending commit beats a new request; req_ready already reflects that.
                if (pending_q) begin
                    state_d = ST_COMMIT;
                    scan_d  = '0;
                end else if (bus.req_valid) begin
                    req_d.component = bus.req_component;
                    req_d.child     = bus.req_child;
                    req_d.visible   = bus.req_visible;
                    req_d.flip      = bus.req_flip;
                    req_d.x         = bus.req_x;
                    req_d.y         = bus.req_y;
                    req_d.attr      = bus.req_attr;
                    idx_d           = '0;
                    state_d         = ST_UPD;
                end
            end
            ST_UPD: begin
                wr_valid_c = 1'b1;
                f_comp     = req_q.component;
                f_child    = req_q.child;
                f_act      = ACT_UPDATE;
                f_type     = upd_type(idx_q);
                f_data     = upd_data(req_q, idx_q);
                if (wr_fire) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                wr_valid_c = COMP_MASK[scan_q];
                f_comp     = scan_q;
                f_act      = ACT_COMMIT;
                // Absent IDs cost one scan cycle each with no word on the bus.
                if (!COMP_MASK[scan_q] || wr_fire) begin
                    if (scan_q == 6'd63) begin
                        state_d    = ST_IDLE;
                        back_buf_d = ~back_buf_q;
                        done_d     = 1'b1;
                        pending_d  = 1'b0;
                    end else begin
                        scan_d = scan_q + 6'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    sprite_cmd_pack u_pack (
        .component_i (f_comp),
        .child_i     (f_child),
        .action_i    (f_act),
        .type_i      (f_type),
        .toggle_i    (back_buf_q),
        .data_i      (f_data),
        .word_o      (packed_word)
    );

    assign bus.req_ready   = (state_q == ST_IDLE) && !pending_q;
    assign bus.wr_valid    = wr_valid_c;
    assign bus.writedata   = wr_valid_c ? packed_word : IDLE_WORD;
    assign bus.back_buf    = back_buf_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.commit_done = done_q;

endmodule

// File: tb/tb_sprite_cmd_encoder.sv
// tb/tb_sprite_cmd_encoder.sv - directed and randomized bench for sprite_cmd_encoder
module tb_sprite_cmd_encoder;

    localparam logic [63:0] MASK = 64'h0000_0000_0000_0400;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sprite_cmd_if bus();

    sprite_cmd_encoder #(.COMP_MASK(MASK), .IDLE_WORD(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic        model_buf = 1'b1;
    logic        outstanding = 1'b0;
    logic        rand_rdy = 1'b0;
    logic        mon_en = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] held_word = '0;

    logic [31:0] t_exp[4];
    logic        sched[7];
    int          wsel[7];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int comp, input int child, input int act,
                                       input int typ, input int tog, input int data);
        return (32'(comp) << 26) | (32'(child) << 21) | (32'(act) << 17) |
               (32'(typ) << 14) | (32'(tog) << 13) | 32'(data);
    endfunction

    task automatic push_update(input int c, input int ch, input int v, input int f,
                               input int x, input int y, input int a);
        exp_q.push_back(mk(c, ch, 1, 1, int'(model_buf), (v << 12) | (f << 11)));
        exp_q.push_back(mk(c, ch, 1, 2, int'(model_buf), x));
        exp_q.push_back(mk(c, ch, 1, 3, int'(model_buf), y));
        exp_q.push_back(mk(c, ch, 1, 4, int'(model_buf), a));
    endtask

    task automatic push_commit();
        for (int id = 0; id < 64; id++)
            if (MASK[id]) exp_q.push_back(mk(id, 0, 15, 0, int'(model_buf), 0));
        model_buf   = ~model_buf;
        outstanding = 1'b1;
    endtask

    task automatic drive_req(input int c, input int ch, input int v, input int f,
                             input int x, input int y, input int a);
        bus.req_component = 6'(c);
        bus.req_child     = 5'(ch);
        bus.req_visible   = 1'(v);
        bus.req_flip      = 1'(f);
        bus.req_x         = 10'(x);
        bus.req_y         = 10'(y);
        bus.req_attr      = 10'(a);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) bus.wr_ready = 1'($urandom_range(0, 1));
    endtask

    // Stream monitor: every consumed word must match the reference queue.
    always @(negedge clk) begin
        if (reset || !mon_en) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", bus.wr_valid, 1);
                check("hold_data", bus.writedata, held_word);
            end
            if (bus.wr_valid && bus.wr_ready) begin
                logic [31:0] e;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
                check("stream_word", bus.writedata, e);
            end else if (!bus.wr_valid) begin
                check("idle_word", bus.writedata, 32'h0);
            end
            stall_prev = bus.wr_valid && !bus.wr_ready;
            held_word  = bus.writedata;
            if (bus.commit_done) outstanding = 1'b0;
        end
    end

    initial begin
        int n, nwords, k;
        logic [31:0] last;

        t_exp = '{32'h2802_7000, 32'h2802_A064, 32'h2802_E0C8, 32'h2803_2005};
        sched = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        wsel  = '{0, 1, 2, 2, 2, 2, 3};

        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.commit_req = 1'b0;
        bus.wr_ready = 1'b1;
        drive_req(0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        reset = 1'b0;
        check("rst_writedata", bus.writedata, 32'h0);
        check("rst_wr_valid", bus.wr_valid, 0);
        check("rst_back_buf", bus.back_buf, 1);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_commit_done", bus.commit_done, 0);
        mon_en = 1'b1;

        // single update, wr_ready held high
        drive_req(10, 0, 1, 0, 100, 200, 5);
        bus.req_valid = 1'b1;
        push_update(10, 0, 1, 0, 100, 200, 5);
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("upd_valid", bus.wr_valid, 1);
            check("upd_word", bus.writedata, t_exp[i]);
            tick();
        end
        check("upd_end_valid", bus.wr_valid, 0);
        check("upd_end_req_ready", bus.req_ready, 1);

        // backpressure on word 2
        bus.req_valid = 1'b1;
        push_update(10, 0, 1, 0, 100, 200, 5);
        tick();
        bus.req_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 7; i++) begin
            bus.wr_ready = sched[i];
            check("bp_valid", bus.wr_valid, 1);
            check("bp_word", bus.writedata, t_exp[wsel[i]]);
            if (bus.wr_valid) n++;
            tick();
        end
        bus.wr_ready = 1'b1;
        check("bp_end_valid", bus.wr_valid, 0);
        check("bp_word_cycles", n, 7);

        // commit with back_buf = 1
        check("cm_buf_before", bus.back_buf, 1);
        bus.commit_req = 1'b1;
        push_commit();
        tick();
        bus.commit_req = 1'b0;
        n = 0; nwords = 0; last = '0;
        while (!bus.commit_done && n < 200) begin
            if (bus.wr_valid && bus.wr_ready) begin nwords++; last = bus.writedata; end
            tick();
            n++;
        end
        check("cm_latency", n, 65);
        check("cm_nwords", nwords, 1);
        check("cm_word", last, 32'h281E_2000);
        check("cm_back_buf", bus.back_buf, 0);
        tick();
        check("cm_done_pulse", bus.commit_done, 0);

        // reset during commit scan
        bus.commit_req = 1'b1;
        push_commit();
        tick();
        bus.commit_req = 1'b0;
        repeat (40) tick();
        check("rmc_busy", bus.busy, 1);
        reset = 1'b1;
        exp_q.delete();
        model_buf = 1'b1;
        outstanding = 1'b0;
        tick();
        check("rmc_wr_valid", bus.wr_valid, 0);
        check("rmc_writedata", bus.writedata, 32'h0);
        check("rmc_back_buf", bus.back_buf, 1);
        check("rmc_busy_after", bus.busy, 0);
        check("rmc_req_ready", bus.req_ready, 1);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 80; i++) begin
            if (bus.commit_done || bus.wr_valid) n++;
            tick();
        end
        check("rmc_no_activity", n, 0);

        // commit requested during update word 1, second pulse mid-commit
        drive_req(10, 3, 0, 1, 7, 9, 1023);
        bus.req_valid = 1'b1;
        push_update(10, 3, 0, 1, 7, 9, 1023);
        tick();
        bus.req_valid = 1'b0;
        nwords = 0; last = '0; k = 0; n = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            bus.commit_req = (cyc == 1 || cyc == 30);
            if (cyc == 1) push_commit();
            if (bus.wr_valid && bus.wr_ready) begin nwords++; last = bus.writedata; end
            if (bus.commit_done) break;
            if (bus.req_ready) k++;
            tick();
            n++;
        end
        bus.commit_req = 1'b0;
        check("cdu_latency", n, 69);
        check("cdu_req_ready_low", k, 0);
        check("cdu_nwords", nwords, 5);
        check("cdu_commit_word", last, 32'h281E_2000);
        check("cdu_back_buf", bus.back_buf, 0);
        n = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (bus.commit_done || bus.wr_valid) n++;
        end
        check("cdu_no_second_commit", n, 0);

        // randomized mix of updates and commits under random backpressure
        rand_rdy = 1'b1;
        for (int op = 0; op < 40; op++) begin
            if ($urandom_range(0, 3) == 0 && !outstanding) begin
                bus.commit_req = 1'b1;
                push_commit();
                tick();
                bus.commit_req = 1'b0;
            end else begin
                int c, ch, v, f, x, y, a;
                c = $urandom_range(0, 63); ch = $urandom_range(0, 31);
                v = $urandom_range(0, 1);  f = $urandom_range(0, 1);
                x = $urandom_range(0, 1023); y = $urandom_range(0, 1023);
                a = $urandom_range(0, 1023);
                drive_req(c, ch, v, f, x, y, a);
                bus.req_valid = 1'b1;
                k = 0;
                while (!bus.req_ready && k < 400) begin tick(); k++; end
                check("rnd_req_ready", bus.req_ready, 1);
                push_update(c, ch, v, f, x, y, a);
                tick();
                bus.req_valid = 1'b0;
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        k = 0;
        while ((exp_q.size() != 0 || bus.busy || outstanding) && k < 3000) begin tick(); k++; end
        rand_rdy = 1'b0;
        bus.wr_ready = 1'b1;
        check("rnd_drained", exp_q.size(), 0);
        check("rnd_busy", bus.busy, 0);
        check("rnd_back_buf", bus.back_buf, model_buf);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
